// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box, round constants, round count and key-generator states.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        KG_IDLE,
        KG_EXPAND,
        KG_START,
        KG_WAIT
    } kg_state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round constant for rounds 1..10; any other index yields zero.
    function automatic logic [7:0] rcon_byte(input logic [3:0] k);
        case (k)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion round: previous round key plus Rcon gives the next round key.
module aes_key_round (
    input  logic [127:0] prev_key,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);
    import aes_pkg::*;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = prev_key;

    // RotWord is a left byte rotate of the last word before substitution.
    assign t = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/engine_key_gen.sv
// AES-128 key schedule feeding the round transformer. ENGINE_KEY_GEN_COMB_EN selects a
// fully combinational 10-round expansion; otherwise one round is computed per clock.
module engine_key_gen (
    input  logic         clk,
    input  logic         rst_,
    input  logic [127:0] key_in,
    input  logic         engine_start,
    input  logic         transformer_done,
    output logic         transformer_start,
    output logic [127:0] round0_key,
    output logic [127:0] round1_key,
    output logic [127:0] round2_key,
    output logic [127:0] round3_key,
    output logic [127:0] round4_key,
    output logic [127:0] round5_key,
    output logic [127:0] round6_key,
    output logic [127:0] round7_key,
    output logic [127:0] round8_key,
    output logic [127:0] round9_key,
    output logic [127:0] round10_key
);
    import aes_pkg::*;

    kg_state_t    state, state_nxt;
    logic [127:0] rk [0:NUM_ROUNDS];

`ifdef ENGINE_KEY_GEN_COMB_EN
    logic [127:0] chain [0:NUM_ROUNDS];

    assign chain[0] = key_in;

    for (genvar r = 1; r <= NUM_ROUNDS; r++) begin : g_round
        aes_key_round u_round (
            .prev_key (chain[r-1]),
            .rcon     (rcon_byte(4'(r))),
            .next_key (chain[r])
        );
    end
`else
    localparam logic [3:0] LAST_STEP = 4'(NUM_ROUNDS);

    // step_cnt names the round key written on the next EXPAND edge; LAST_STEP+1 means done.
    logic [3:0]   step_cnt;
    logic [127:0] round_prev, round_next;

    always_comb begin
        round_prev = '0;
        if (step_cnt != 4'd0 && step_cnt <= LAST_STEP) begin
            round_prev = rk[step_cnt - 4'd1];
        end
    end

    aes_key_round u_round (
        .prev_key (round_prev),
        .rcon     (rcon_byte(step_cnt)),
        .next_key (round_next)
    );
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            KG_IDLE: begin
                if (engine_start) begin
`ifdef ENGINE_KEY_GEN_COMB_EN
                    state_nxt = KG_START;
`else
                    state_nxt = KG_EXPAND;
`endif
                end
            end
            KG_EXPAND: begin
`ifdef ENGINE_KEY_GEN_COMB_EN
                state_nxt = KG_START;
`else
                if (step_cnt > LAST_STEP) begin
                    state_nxt = KG_START;
                end
`endif
            end
            KG_START: state_nxt = KG_WAIT;
            KG_WAIT: begin
                if (transformer_done) begin
                    state_nxt = KG_IDLE;
                end
            end
            default: state_nxt = KG_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            state             <= KG_IDLE;
            transformer_start <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                rk[i] <= '0;
            end
`ifndef ENGINE_KEY_GEN_COMB_EN
            step_cnt <= '0;
`endif
        end else begin
            state             <= state_nxt;
            transformer_start <= (state_nxt == KG_START);
`ifdef ENGINE_KEY_GEN_COMB_EN
            if (state == KG_IDLE && engine_start) begin
                for (int i = 0; i <= NUM_ROUNDS; i++) begin
                    rk[i] <= chain[i];
                end
            end
`else
            if (state == KG_IDLE && engine_start) begin
                rk[0]    <= key_in;
                step_cnt <= 4'd1;
            end else if (state == KG_EXPAND && step_cnt <= LAST_STEP) begin
                rk[step_cnt] <= round_next;
                step_cnt     <= step_cnt + 4'd1;
            end
`endif
        end
    end

    assign round0_key  = rk[0];
    assign round1_key  = rk[1];
    assign round2_key  = rk[2];
    assign round3_key  = rk[3];
    assign round4_key  = rk[4];
    assign round5_key  = rk[5];
    assign round6_key  = rk[6];
    assign round7_key  = rk[7];
    assign round8_key  = rk[8];
    assign round9_key  = rk[9];
    assign round10_key = rk[10];

endmodule

// File: tb/tb_engine_key_gen.sv
// Self-checking bench for engine_key_gen; expected keys come from a GF(2^8)-derived
// S-box and a word-wise FIPS-197 key expansion, independent of the RTL tables.
module tb_engine_key_gen;

`ifdef ENGINE_KEY_GEN_COMB_EN
    localparam int EXP_TS_EDGE = 0;
`else
    localparam int EXP_TS_EDGE = 11;
`endif

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk;
    logic         rst_;
    logic [127:0] key_in;
    logic         engine_start;
    logic         transformer_done;
    logic         transformer_start;
    logic [127:0] act_rk [11];

    int checks = 0;
    int errors = 0;

    logic [7:0]   m_sbox [256];
    logic [127:0] exp_rk [11];
    logic [127:0] exp_q [$];

    typedef struct {
        logic [127:0] key;
        logic [127:0] r1;
        logic [127:0] r10;
    } vec_t;

    vec_t vecs [2];

    engine_key_gen dut (
        .clk               (clk),
        .rst_              (rst_),
        .key_in            (key_in),
        .engine_start      (engine_start),
        .transformer_done  (transformer_done),
        .transformer_start (transformer_start),
        .round0_key        (act_rk[0]),
        .round1_key        (act_rk[1]),
        .round2_key        (act_rk[2]),
        .round3_key        (act_rk[3]),
        .round4_key        (act_rk[4]),
        .round5_key        (act_rk[5]),
        .round6_key        (act_rk[6]),
        .round7_key        (act_rk[7]),
        .round8_key        (act_rk[8]),
        .round9_key        (act_rk[9]),
        .round10_key       (act_rk[10])
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gf_mul(8'(v), 8'(x)) == 8'h01) inv = 8'(x);
            end
            m_sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_schedule(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] temp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {m_sbox[temp[31:24]], m_sbox[temp[23:16]], m_sbox[temp[15:8]], m_sbox[temp[7:0]]}
                       ^ {rc, 24'h000000};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r < 11; r++) begin
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            exp_q.push_back(exp_rk[r]);
        end
    endtask

    // Scoreboard
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk_keys_vs_queue(input string tag);
        logic [127:0] e;
        for (int r = 0; r < 11; r++) begin
            if (exp_q.size() == 0) begin
                chk($sformatf("%s_queue_empty_r%0d", tag, r), 128'd0, 128'd1);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("%s_round%0d", tag, r), act_rk[r], e);
            end
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_start(input logic [127:0] k);
        engine_start = 1'b1;
        key_in       = k;
        step();
        engine_start = 1'b0;
        key_in       = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Called right after the accepting edge; reports the first edge index with
    // transformer_start high and how many sampled edges had it high.
    task automatic observe(input bit noise, output int idx, output int cnt);
        idx = -1;
        cnt = 0;
        if (transformer_start) begin
            idx = 0;
            cnt = 1;
        end
        for (int i = 1; i <= EXP_TS_EDGE + 8; i++) begin
            if (noise) begin
                engine_start     = 1'($urandom_range(0, 1));
                key_in           = {$urandom, $urandom, $urandom, $urandom};
                transformer_done = (i <= EXP_TS_EDGE) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            step();
            if (transformer_start) begin
                if (idx < 0) idx = i;
                cnt++;
            end
        end
        engine_start     = 1'b0;
        transformer_done = 1'b0;
    endtask

    task automatic chk_timing(input string tag, input int idx, input int cnt);
        chk({tag, "_ts_edge"}, 128'(idx), 128'(EXP_TS_EDGE));
        chk({tag, "_ts_count"}, 128'(cnt), 128'd1);
    endtask

    task automatic release_wait();
        transformer_done = 1'b1;
        step();
        transformer_done = 1'b0;
    endtask

    int idx;
    int cnt;
    logic [127:0] rkey;

    initial begin
        vecs[0] = '{key: KEY_A1,
                    r1:  128'ha0fafe1788542cb123a339392a6c7605,
                    r10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{key: 128'h0,
                    r1:  128'h62636363626363636263636362636363,
                    r10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        rst_             = 1'b1;
        key_in           = '0;
        engine_start     = 1'b0;
        transformer_done = 1'b0;
        build_sbox();
        step();
        step();
        chk("reset_tstart", 128'(transformer_start), 128'd0);
        for (int r = 0; r < 11; r++) chk($sformatf("reset_round%0d", r), act_rk[r], 128'd0);
        rst_ = 1'b0;
        step();

        // Known-answer vectors
        for (int v = 0; v < 2; v++) begin
            model_schedule(vecs[v].key);
            apply_start(vecs[v].key);
            observe(1'b0, idx, cnt);
            chk_timing($sformatf("kat%0d", v), idx, cnt);
            chk($sformatf("kat%0d_round0", v), act_rk[0], vecs[v].key);
            chk($sformatf("kat%0d_round1", v), act_rk[1], vecs[v].r1);
            chk($sformatf("kat%0d_round10", v), act_rk[10], vecs[v].r10);
            chk_keys_vs_queue($sformatf("kat%0d", v));
            release_wait();
            step();
            chk($sformatf("kat%0d_idle_tstart", v), 128'(transformer_start), 128'd0);
        end

        // Random keys with stray start/done activity while busy
        for (int n = 0; n < 4; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            model_schedule(rkey);
            transformer_done = 1'b1;
            step();
            transformer_done = 1'b0;
            chk($sformatf("rnd%0d_idle_done_tstart", n), 128'(transformer_start), 128'd0);
            apply_start(rkey);
            observe(1'b1, idx, cnt);
            chk_timing($sformatf("rnd%0d", n), idx, cnt);
            chk_keys_vs_queue($sformatf("rnd%0d", n));
            release_wait();
        end

        // Reset mid-expansion
        rkey = {$urandom, $urandom, $urandom, $urandom};
        apply_start(rkey);
        for (int i = 1; i <= 4; i++) step();
        rst_ = 1'b1;
        step();
        rst_ = 1'b0;
        chk("midrst_tstart", 128'(transformer_start), 128'd0);
        for (int r = 0; r < 11; r++) chk($sformatf("midrst_round%0d", r), act_rk[r], 128'd0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (transformer_start) cnt++;
        end
        chk("midrst_no_tstart", 128'(cnt), 128'd0);
        model_schedule(KEY_A1);
        apply_start(KEY_A1);
        observe(1'b0, idx, cnt);
        chk_timing("post_rst", idx, cnt);
        chk_keys_vs_queue("post_rst");

        // Still in WAIT: done and start together return to IDLE without accepting
        rkey = {$urandom, $urandom, $urandom, $urandom};
        transformer_done = 1'b1;
        engine_start     = 1'b1;
        key_in           = rkey;
        step();
        transformer_done = 1'b0;
        model_schedule(KEY_A1);
        apply_start(KEY_A1);
        observe(1'b0, idx, cnt);
        chk_timing("done_start", idx, cnt);
        chk_keys_vs_queue("done_start");
        release_wait();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/engine_key_gen.md
Name: engine_key_gen

Overview:
- AES-128 key-schedule block in the encryption engine, between the byte-serial input interface and the round transformer.
- On a start pulse it latches the 128-bit cipher key and expands it into the 11 round keys (round0..round10).
- It then pulses transformer_start and waits for transformer_done before it accepts another start.
- Round keys stay registered and stable on the outputs for the whole transformer run.

Parameters:
- None. AES-128 only; 10 rounds fixed.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_  input  1  reset, synchronous, active-high (port name kept as rst_)
- key_in  input  128  cipher key; key_in[127:120] is byte 0 (FIPS-197 order); sampled only on an accepted start
- engine_start  input  1  start request from input interface; sampled in IDLE only
- transformer_done  input  1  completion from round transformer; sampled in WAIT only
- transformer_start  output  1  one-cycle registered pulse; all round keys valid
- round0_key .. round10_key  output  128 each  registered round keys; round0_key = key_in

Behaviour:
- Reset (rst_=1 at a clock edge): state=IDLE, step counter=0, transformer_start=0, all 11 round keys=0. Reset wins over every other input. Reset mid-expansion or mid-WAIT aborts to IDLE with keys cleared.
- States:
  - IDLE -> EXPAND on engine_start=1.
  - EXPAND -> START after round10 is written.
  - START -> WAIT unconditionally.
  - WAIT -> IDLE on transformer_done=1.
- Timing, with edge E0 the edge that samples engine_start=1 in IDLE:
  - At E0: round0_key<=key_in; counter<=1.
  - At edge Ek (k=1..10): round{k}_key<=expand(round{k-1}_key, Rcon[k]).
  - At E11: transformer_start=1 for exactly one cycle.
  - At E12: transformer_start=0; state=WAIT.
  - Latency, start to transformer_start visible: 11 cycles.
- Expansion, with words w0..w3 = key bits [127:96]..[31:0]:
  - t = SubWord(RotWord(w3)) ^ {Rcon[k],24'h0}.
  - w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
  - RotWord is a left byte rotate. SubWord applies the AES S-box to each byte.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- Until overwritten in a new run, round keys not yet recomputed keep their previous values.
- engine_start while not IDLE: ignored, no restart.
- transformer_done outside WAIT: ignored.
- engine_start and transformer_done both high in WAIT: go to IDLE only; the start is not accepted that cycle.
- key_in changes after E0: no effect on the current run.
- Back-to-back: in IDLE the block accepts a new start in the cycle after returning from WAIT.

Optional Feature:
- Macro ENGINE_KEY_GEN_COMB_EN.
- Defined:
  - All 10 expansions are computed combinationally (40 S-box instances) and all 11 round keys are registered together at E0.
  - EXPAND state is skipped: IDLE -> START, so transformer_start is high in the cycle after E0 (latency 1).
  - Other rules unchanged.
- Undefined: the iterative 11-cycle schedule above, with one 4-byte S-box bank shared across rounds.

Decomposition:
- Shared package aes_pkg holds:
  - 256-entry S-box constant or function.
  - Rcon table.
  - Round count constant (10).
  - Key-generator state enum (IDLE, EXPAND, START, WAIT).
- One natural sub-module, aes_key_round: combinational single-round expansion (prev key + rcon -> next key). It is instantiated once (iterative) or 10 times (COMB_EN).

Test Plan:
- FIPS-197 A.1 key, start pulse, then done pulse in WAIT:
  - key_in=2b7e151628aed2a6abf7158809cf4f3c, 1-cycle start.
  - round1_key=a0fafe1788542cb123a339392a6c7605; round10_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - transformer_start high exactly 1 cycle, 11 cycles after start (1 with COMB_EN).
  - Then done=1 in WAIT -> IDLE.
- All-zero key:
  - round1_key=62636363626363636263636362636363; round10_key=b4ef5bcb3e92e21123e951cf6f8f188e.
- Start with a new key asserted during EXPAND and WAIT -> ignored; keys match the first key; no second transformer_start until done then a fresh start.
- rst_=1 at expansion step 5 -> next cycle IDLE, all round keys 0, no transformer_start; a subsequent start gives a correct full schedule.
- transformer_done pulsed in IDLE/EXPAND -> no state change.
- Second run:
  - In WAIT, done=1 and start=1 together -> IDLE, start not taken.
  - A start next cycle with the A.1 key -> correct keys, and start-to-transformer_start latency again 11 (1 with COMB_EN).
